// File: rtl/branch_resolve_pkg.sv
// Shared CPU definitions for the branch-resolution block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_resolve_pkg;

    localparam int DEFAULT_DEPTH        = 4;
    localparam int DEFAULT_FLUSH_CYCLES = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // One fetched instruction's prediction record.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pre_pc;
    } pred_rec_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order queue of in-flight prediction records with single-cycle clear.
// Latency: push visible at head the cycle after write; head is a combinational read.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports: push/push_rec write, pop advances head, clear empties (wins over push/pop),
//        head_rec is the oldest record, occupancy counts 0..DEPTH.
module pred_fifo
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  pred_rec_t                push_rec,
    input  logic                     pop,
    input  logic                     clear,
    output pred_rec_t                head_rec,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    pred_rec_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    // Pointers are exactly AW bits, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: count gates every use of the contents.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_rec;
    end

    assign head_rec  = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/branch_resolve.sv
// Resolves predicted next-PCs against EX results; redirects and squashes on mispredict.
// Latency: redirect_valid/flush rise the cycle after the mispredicting resolve.
// Backpressure: push_ready low while full or during the flush window; dropped pushes have no effect.
// Ports: push_* record fetch predictions, res_* resolve the oldest, redirect_*/flush steer fetch,
//        occupancy/mispredict_cnt/underflow are status.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic [31:0]              push_pre_pc,
    output logic                     push_ready,
    input  logic                     res_valid,
    input  logic [31:0]              res_next_pc,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     flush,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              mispredict_cnt,
    output logic                     underflow
);

    localparam int            OW       = $clog2(DEPTH) + 1;
    localparam logic [OW-1:0] FULL_LVL = OW'(DEPTH);
    localparam int            FW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [FW-1:0]   flush_left;   // flush cycles still to come after the current one
    logic [15:0]     cnt_q;
    pred_rec_t       head_rec;
    pred_rec_t       push_rec;
    logic            in_run;
    logic            empty;
    logic            resolve;
    logic            mispredict;
    logic            pop;
    logic            accept;
    logic            unused_head_pc;

    assign in_run     = (state == ST_RUN);
    assign empty      = (occupancy == '0);
    // Ready uses pre-pop occupancy: a full queue refuses a push even while popping.
    assign push_ready = in_run && (occupancy < FULL_LVL);

    assign resolve    = in_run && res_valid && !empty;
    assign mispredict = resolve && (head_rec.pre_pc != res_next_pc);
    assign pop        = resolve && (head_rec.pre_pc == res_next_pc);
    // A push coinciding with a mispredict is on the wrong path and is discarded.
    assign accept     = push_valid && push_ready && !mispredict;

    assign push_rec.pc     = push_pc;
    assign push_rec.pre_pc = push_pre_pc;

    // The PC travels with the record for debug visibility only.
    assign unused_head_pc = ^head_rec.pc;

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_rec  (push_rec),
        .pop       (pop),
        .clear     (mispredict),
        .head_rec  (head_rec),
        .occupancy (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (mispredict)        state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_left == '0)  state_nxt = ST_RUN;
            default:                         state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_left <= '0;
        end else if (mispredict) begin
            flush_left <= FW'(FLUSH_CYCLES - 1);
        end else if (!in_run && flush_left != '0) begin
            flush_left <= flush_left - 1'b1;
        end
    end

    // redirect_pc only changes on a mispredict, so it holds between redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= res_next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'h0;
        end else if (mispredict && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (in_run && res_valid && empty) begin
            underflow <= 1'b1;
        end
    end

    assign flush          = (state == ST_FLUSH);
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;
    import branch_resolve_pkg::*;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc = 32'h0;
    logic [31:0] push_pre_pc = 32'h0;
    logic        push_ready;
    logic        res_valid = 1'b0;
    logic [31:0] res_next_pc = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [2:0]  occupancy;
    logic [15:0] mispredict_cnt;
    logic        underflow;

    branch_resolve #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .push_valid     (push_valid),
        .push_pc        (push_pc),
        .push_pre_pc    (push_pre_pc),
        .push_ready     (push_ready),
        .res_valid      (res_valid),
        .res_next_pc    (res_next_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .occupancy      (occupancy),
        .mispredict_cnt (mispredict_cnt),
        .underflow      (underflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic [31:0] ppre;
        logic        rv;
        logic [31:0] rnpc;
        logic        e_rdy;
        int          e_occ;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_fl;
        int          e_cnt;
        logic        e_uf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic pv, logic [31:0] ppc, logic [31:0] ppre, logic rv,
                                logic [31:0] rnpc, logic e_rdy, int e_occ, logic e_redir,
                                logic [31:0] e_rpc, logic e_fl, int e_cnt, logic e_uf);
        vec_t v;
        v.pv = pv; v.ppc = ppc; v.ppre = ppre; v.rv = rv; v.rnpc = rnpc;
        v.e_rdy = e_rdy; v.e_occ = e_occ; v.e_redir = e_redir; v.e_rpc = e_rpc;
        v.e_fl = e_fl; v.e_cnt = e_cnt; v.e_uf = e_uf;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    pred_rec_t   mq[$];
    int          m_flush_left;
    logic        m_redir;
    logic [31:0] m_rpc;
    int          m_cnt;
    logic        m_uf;

    task automatic model_reset();
        mq.delete();
        m_flush_left = 0;
        m_redir = 1'b0;
        m_rpc = 32'h0;
        m_cnt = 0;
        m_uf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit ready;
        pred_rec_t r;
        ready = (m_flush_left == 0) && (mq.size() < DEPTH);
        m_redir = 1'b0;
        if (m_flush_left > 0) begin
            m_flush_left--;
            return;
        end
        if (res_valid && mq.size() == 0) begin
            m_uf = 1'b1;
        end else if (res_valid && mq[0].pre_pc != res_next_pc) begin
            mq.delete();
            m_rpc = res_next_pc;
            m_redir = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            m_flush_left = FLUSH_CYCLES;
            return;
        end else if (res_valid) begin
            void'(mq.pop_front());
        end
        if (push_valid && ready) begin
            r.pc = push_pc;
            r.pre_pc = push_pre_pc;
            mq.push_back(r);
        end
    endtask

    task automatic check_model();
        chk("rand_ready", {31'h0, push_ready}, {31'h0, (m_flush_left == 0) && (mq.size() < DEPTH)});
        chk("rand_occ",   {29'h0, occupancy}, mq.size());
        chk("rand_redir", {31'h0, redirect_valid}, {31'h0, m_redir});
        chk("rand_rpc",   redirect_pc, m_rpc);
        chk("rand_flush", {31'h0, flush}, {31'h0, m_flush_left > 0});
        chk("rand_cnt",   {16'h0, mispredict_cnt}, m_cnt);
        chk("rand_uf",    {31'h0, underflow}, {31'h0, m_uf});
    endtask

    task automatic idle();
        push_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", {31'h0, push_ready}, 32'd1);
        chk("rst_occ",   {29'h0, occupancy}, 32'd0);
        chk("rst_redir", {31'h0, redirect_valid}, 32'd0);
        chk("rst_rpc",   redirect_pc, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'd0);
        chk("rst_cnt",   {16'h0, mispredict_cnt}, 32'd0);
        chk("rst_uf",    {31'h0, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //            pv  push_pc       pre_pc        rv  res_next_pc   rdy occ rdv rpc           fl cnt uf
        // correct prediction
        vt.push_back(mk(1, 32'h00400000, 32'h00400004, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0));
        vt.push_back(mk(0, 32'h0,        32'h0,        1, 32'h00400004, 1, 0, 0, 32'h0,        0, 0, 0));
        // mispredict with 3 in flight, same-cycle push discarded, pushes during flush dropped
        vt.push_back(mk(1, 32'h00400008, 32'h00400010, 0, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0));
        vt.push_back(mk(1, 32'h0040000C, 32'h00400014, 0, 32'h0,        1, 2, 0, 32'h0,        0, 0, 0));
        vt.push_back(mk(1, 32'h00400010, 32'h00400018, 0, 32'h0,        1, 3, 0, 32'h0,        0, 0, 0));
        vt.push_back(mk(1, 32'h00400020, 32'h00400024, 1, 32'h00400100, 0, 0, 1, 32'h00400100, 1, 1, 0));
        vt.push_back(mk(1, 32'h00500000, 32'h00500004, 0, 32'h0,        0, 0, 0, 32'h00400100, 1, 1, 0));
        vt.push_back(mk(1, 32'h00500000, 32'h00500004, 1, 32'h00500004, 1, 0, 0, 32'h00400100, 0, 1, 0));
        // fill to full, 5th dropped, full+pop does not accept, drain
        vt.push_back(mk(1, 32'h00600000, 32'h00600004, 0, 32'h0,        1, 1, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(1, 32'h00600004, 32'h00600008, 0, 32'h0,        1, 2, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(1, 32'h00600008, 32'h0060000C, 0, 32'h0,        1, 3, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(1, 32'h0060000C, 32'h00600010, 0, 32'h0,        0, 4, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(1, 32'h00700000, 32'h00700004, 0, 32'h0,        0, 4, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(1, 32'h00700000, 32'h00700004, 1, 32'h00600004, 1, 3, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(0, 32'h0,        32'h0,        1, 32'h00600008, 1, 2, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(0, 32'h0,        32'h0,        1, 32'h0060000C, 1, 1, 0, 32'h00400100, 0, 1, 0));
        vt.push_back(mk(0, 32'h0,        32'h0,        1, 32'h00600010, 1, 0, 0, 32'h00400100, 0, 1, 0));
        // resolve on empty queue: sticky underflow, nothing else changes
        vt.push_back(mk(0, 32'h0,        32'h0,        1, 32'h00700004, 1, 0, 0, 32'h00400100, 0, 1, 1));
        vt.push_back(mk(0, 32'h0,        32'h0,        0, 32'h0,        1, 0, 0, 32'h00400100, 0, 1, 1));

        foreach (vt[i]) begin
            push_valid  = vt[i].pv;
            push_pc     = vt[i].ppc;
            push_pre_pc = vt[i].ppre;
            res_valid   = vt[i].rv;
            res_next_pc = vt[i].rnpc;
            tick();
            chk($sformatf("vec%0d_ready", i), {31'h0, push_ready}, {31'h0, vt[i].e_rdy});
            chk($sformatf("vec%0d_occ", i),   {29'h0, occupancy}, vt[i].e_occ);
            chk($sformatf("vec%0d_redir", i), {31'h0, redirect_valid}, {31'h0, vt[i].e_redir});
            chk($sformatf("vec%0d_rpc", i),   redirect_pc, vt[i].e_rpc);
            chk($sformatf("vec%0d_flush", i), {31'h0, flush}, {31'h0, vt[i].e_fl});
            chk($sformatf("vec%0d_cnt", i),   {16'h0, mispredict_cnt}, vt[i].e_cnt);
            chk($sformatf("vec%0d_uf", i),    {31'h0, underflow}, {31'h0, vt[i].e_uf});
        end

        // Reset asserted during the second flush cycle
        push_valid = 1'b1; push_pc = 32'h00800000; push_pre_pc = 32'h00800004; res_valid = 1'b0;
        tick();
        push_valid = 1'b0; res_valid = 1'b1; res_next_pc = 32'h00800008;
        tick();
        chk("mrst_redir_pulse", {31'h0, redirect_valid}, 32'd1);
        idle();
        tick();
        chk("mrst_flush_2nd", {31'h0, flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_flush",  {31'h0, flush}, 32'd0);
        chk("mrst_redir",  {31'h0, redirect_valid}, 32'd0);
        chk("mrst_occ",    {29'h0, occupancy}, 32'd0);
        chk("mrst_cnt",    {16'h0, mispredict_cnt}, 32'd0);
        chk("mrst_ready",  {31'h0, push_ready}, 32'd1);
        chk("mrst_rpc",    redirect_pc, 32'h0);
        chk("mrst_uf",     {31'h0, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_valid = 1'b1; push_pc = 32'h00900000; push_pre_pc = 32'h00900004;
        tick();
        chk("post_rst_push_occ", {29'h0, occupancy}, 32'd1);
        idle();

        // Counter saturation from a preloaded value
        force dut.cnt_q = 16'hFFFE;
        #1;
        release dut.cnt_q;
        #1;
        chk("sat_preload", {16'h0, mispredict_cnt}, 32'h0000FFFE);
        res_valid = 1'b1; res_next_pc = 32'hDEAD0000;   // head predicts 0x00900004
        tick();
        chk("sat_reach", {16'h0, mispredict_cnt}, 32'h0000FFFF);
        idle();
        tick();
        tick();
        chk("sat_back_run", {31'h0, flush}, 32'd0);
        push_valid = 1'b1; push_pc = 32'h00A00000; push_pre_pc = 32'h00A00004;
        tick();
        push_valid = 1'b0; res_valid = 1'b1; res_next_pc = 32'h00B00000;
        tick();
        chk("sat_redir", {31'h0, redirect_valid}, 32'd1);
        chk("sat_hold", {16'h0, mispredict_cnt}, 32'h0000FFFF);
        idle();

        // Randomized run against the reference model
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            push_valid  = ($urandom_range(0, 9) < 6);
            push_pc     = $urandom;
            push_pre_pc = $urandom;
            res_valid   = ($urandom_range(0, 9) < 5);
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                res_next_pc = mq[0].pre_pc;
            else
                res_next_pc = $urandom;
            model_step();
            tick();
            check_model();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
